// File: rtl/parity_pipe_if.sv
// Stream interface for parity_pipe: input beat handshake plus the
// per-word result beat travelling downstream.
interface parity_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_chk;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic             out_last;
  logic             frame_parity;
  logic             word_err;

  // Data source / result sink side
  modport master (
    output in_valid, in_data, in_chk, in_last, out_ready,
    input  in_ready, out_valid, out_parity, out_last, frame_parity, word_err
  );

  // Parity pipeline side
  modport slave (
    input  in_valid, in_data, in_chk, in_last, out_ready,
    output in_ready, out_valid, out_parity, out_last, frame_parity, word_err
  );
endinterface

// File: rtl/parity_pipe.sv
// Pipelined XOR-tree parity generator/checker. One register level per tree
// level, global stall on output backpressure, per-frame parity accumulation
// and a saturating word-error counter. WIDTH must be a power of two, 2..64.
module parity_pipe #(
  parameter int WIDTH = 16,
  parameter int ERRW  = 8,
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  parity_pipe_if.slave    bus,
  input  logic            odd_mode,
  input  logic            chk_mode,
  input  logic            clr,
  output logic [ERRW-1:0] err_cnt
);

  // Tree levels are packed into one vector: level k (WIDTH>>k bits) starts
  // at bit WIDTH - 2*(WIDTH>>k), so the final single bit lands at WIDTH-2.
  logic [WIDTH-2:0] tree;
  logic [WIDTH-2:0] tree_nxt;

  logic [STAGES:1]  vld;
  logic [STAGES:1]  last_p;
  logic [STAGES:1]  chk_p;

  logic             stall;
  logic             accept;
  logic             xfer;
  logic             raw;
  logic             word_par;
  logic             acc;

  assign stall        = vld[STAGES] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept       = bus.in_valid & ~stall;
  assign xfer         = vld[STAGES] & bus.out_ready;

  assign raw      = tree[WIDTH-2];
  assign word_par = raw ^ odd_mode;

  // Next value of every tree level: pairwise XOR of the level below it.
  always_comb begin
    tree_nxt = '0;
    for (int i = 0; i < WIDTH / 2; i++) begin
      tree_nxt[i] = bus.in_data[2*i] ^ bus.in_data[2*i+1];
    end
    for (int k = 2; k <= STAGES; k++) begin
      for (int i = 0; i < (WIDTH >> k); i++) begin
        tree_nxt[WIDTH - 2*(WIDTH >> k) + i] =
          tree[WIDTH - 4*(WIDTH >> k) + 2*i] ^
          tree[WIDTH - 4*(WIDTH >> k) + 2*i + 1];
      end
    end
  end

  // Tree registers; frozen as a whole while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tree <= '0;
    end else if (!stall) begin
      tree <= tree_nxt;
    end
  end

  // Valid/last/chk sidebands move with their word; bubbles shift too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= '0;
      last_p <= '0;
      chk_p  <= '0;
    end else if (!stall) begin
      vld[1]    <= accept;
      last_p[1] <= bus.in_last;
      chk_p[1]  <= bus.in_chk;
      for (int k = 2; k <= STAGES; k++) begin
        vld[k]    <= vld[k-1];
        last_p[k] <= last_p[k-1];
        chk_p[k]  <= chk_p[k-1];
      end
    end
  end

  // Result fields are forced low when no beat is presented.
  assign bus.out_valid    = vld[STAGES];
  assign bus.out_parity   = vld[STAGES] & word_par;
  assign bus.out_last     = vld[STAGES] & last_p[STAGES];
  assign bus.frame_parity = vld[STAGES] & (acc ^ word_par);
  assign bus.word_err     = vld[STAGES] & chk_mode & (word_par ^ chk_p[STAGES]);

  // Frame accumulator and error counter advance only on an output transfer;
  // clr overrides any same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= 1'b0;
      err_cnt <= '0;
    end else if (clr) begin
      acc     <= 1'b0;
      err_cnt <= '0;
    end else if (xfer) begin
      acc <= last_p[STAGES] ? 1'b0 : (acc ^ raw);
      if (bus.word_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_parity_pipe.sv
// Directed bench for parity_pipe (WIDTH=16). A narrow-counter instance
// (ERRW=2) carries the main checks; a default-counter twin (ERRW=8) sees
// identical stimulus so saturation can be contrasted with plain counting.
module tb_parity_pipe;
  localparam int WIDTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       odd_mode;
  logic       chk_mode;
  logic       clr;
  logic [1:0] err_cnt;
  logic [7:0] err_cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_pipe_if #(.WIDTH(WIDTH)) bus ();
  parity_pipe_if #(.WIDTH(WIDTH)) bus8 ();

  assign bus8.in_valid  = bus.in_valid;
  assign bus8.in_data   = bus.in_data;
  assign bus8.in_chk    = bus.in_chk;
  assign bus8.in_last   = bus.in_last;
  assign bus8.out_ready = bus.out_ready;

  parity_pipe #(.WIDTH(WIDTH), .ERRW(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .odd_mode (odd_mode),
    .chk_mode (chk_mode),
    .clr      (clr),
    .err_cnt  (err_cnt)
  );

  parity_pipe #(.WIDTH(WIDTH), .ERRW(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus8.slave),
    .odd_mode (odd_mode),
    .chk_mode (chk_mode),
    .clr      (clr),
    .err_cnt  (err_cnt8)
  );

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        ic;
    logic        il;
    logic        ordy;
    logic        odd;
    logic        cm;
    logic        cl;
    logic        e_ir;
    logic        e_ov;
    logic        e_op;
    logic        e_ol;
    logic        e_fp;
    logic        e_we;
    logic [1:0]  e_ec;
    logic [7:0]  e_ec8;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t v(input int iv, input int d, input int ic, input int il,
                             input int ordy, input int odd, input int cm, input int cl,
                             input int ir, input int ov, input int op, input int ol,
                             input int fp, input int we, input int ec, input int ec8);
    vec_t t;
    t.iv    = 1'(iv);
    t.d     = 16'(d);
    t.ic    = 1'(ic);
    t.il    = 1'(il);
    t.ordy  = 1'(ordy);
    t.odd   = 1'(odd);
    t.cm    = 1'(cm);
    t.cl    = 1'(cl);
    t.e_ir  = 1'(ir);
    t.e_ov  = 1'(ov);
    t.e_op  = 1'(op);
    t.e_ol  = 1'(ol);
    t.e_fp  = 1'(fp);
    t.e_we  = 1'(we);
    t.e_ec  = 2'(ec);
    t.e_ec8 = 8'(ec8);
    return t;
  endfunction

  task automatic cmp(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  initial begin
    int n;

    rst_n         = 1'b0;
    odd_mode      = 1'b0;
    chk_mode      = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chk    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    //        iv  data    ic il rdy odd cm clr | ir ov op ol fp we ec ec8
    // single even beat, latency 4
    vt.push_back(v(1, 'h0001, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r0
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r1-3
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0)); // r4
    // odd 3-beat frame back-to-back
    vt.push_back(v(1, 'h0003, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r5
    vt.push_back(v(1, 'h0007, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r6
    vt.push_back(v(1, 'hFFFF, 0, 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r7
    vt.push_back(v(0, 'h0000, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r8
    vt.push_back(v(0, 'h0000, 0, 0, 1, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0)); // r9
    vt.push_back(v(0, 'h0000, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0)); // r10
    vt.push_back(v(0, 'h0000, 0, 0, 1, 1, 0, 0,  1, 1, 1, 1, 0, 0, 0, 0)); // r11
    // next odd frame must start from acc=0
    vt.push_back(v(1, 'h0000, 0, 1, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r12
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0, 'h0000, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r13-15
    vt.push_back(v(0, 'h0000, 0, 0, 1, 1, 0, 0,  1, 1, 1, 1, 1, 0, 0, 0)); // r16
    // even stream of 6 with 4 stalled cycles
    vt.push_back(v(1, 'h0001, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r17
    vt.push_back(v(1, 'h0002, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r18
    vt.push_back(v(1, 'h0003, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r19
    vt.push_back(v(1, 'h0004, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r20
    for (int i = 0; i < 4; i++)
      vt.push_back(v(1, 'h0005, 0, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0)); // r21-24
    vt.push_back(v(1, 'h0005, 0, 0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0)); // r25
    vt.push_back(v(1, 'h0006, 0, 1, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0)); // r26
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0)); // r27
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0)); // r28
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0)); // r29
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 1, 0, 1, 1, 0, 0, 0)); // r30
    // check mode, even
    vt.push_back(v(1, 'h00FF, 1, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r31
    vt.push_back(v(1, 'h00FE, 1, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r32
    for (int i = 0; i < 2; i++)
      vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r33-34
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 0, 1, 0, 0)); // r35
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 1, 1, 1, 1, 0, 1, 1)); // r36
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 1,  1, 0, 0, 0, 0, 0, 1, 1)); // r37 clr
    // five error beats: narrow counter saturates at 3
    for (int i = 0; i < 4; i++)
      vt.push_back(v(1, 'h0000, 1, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r38-41
    vt.push_back(v(1, 'h0000, 1, 1, 1, 0, 1, 0,  1, 1, 0, 1, 0, 1, 0, 0)); // r42
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 0, 1, 1, 1)); // r43
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 0, 1, 2, 2)); // r44
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 0, 1, 3, 3)); // r45
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 1, 0, 1, 0, 1, 3, 4)); // r46
    // one more error beat whose transfer coincides with clr
    vt.push_back(v(1, 'h0000, 1, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 3, 5)); // r47
    for (int i = 0; i < 3; i++)
      vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 3, 5)); // r48-50
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 1,  1, 1, 0, 1, 0, 1, 3, 5)); // r51
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r52
    vt.push_back(v(0, 'h0000, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0)); // r53

    // reset state
    #2;
    cmp("rst_out_valid",    -1, bus.out_valid,    1'b0);
    cmp("rst_in_ready",     -1, bus.in_ready,     1'b1);
    cmp("rst_out_parity",   -1, bus.out_parity,   1'b0);
    cmp("rst_out_last",     -1, bus.out_last,     1'b0);
    cmp("rst_frame_parity", -1, bus.frame_parity, 1'b0);
    cmp("rst_word_err",     -1, bus.word_err,     1'b0);
    cmp("rst_err_cnt",      -1, err_cnt,          2'd0);
    cmp("rst_err_cnt8",     -1, err_cnt8,         8'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vt[r]) begin
      @(posedge clk);
      #1;
      bus.in_valid  = vt[r].iv;
      bus.in_data   = vt[r].d;
      bus.in_chk    = vt[r].ic;
      bus.in_last   = vt[r].il;
      bus.out_ready = vt[r].ordy;
      odd_mode      = vt[r].odd;
      chk_mode      = vt[r].cm;
      clr           = vt[r].cl;
      #1;
      cmp("in_ready",  r, bus.in_ready,  vt[r].e_ir);
      cmp("out_valid", r, bus.out_valid, vt[r].e_ov);
      cmp("err_cnt",   r, err_cnt,       vt[r].e_ec);
      cmp("err_cnt8",  r, err_cnt8,      vt[r].e_ec8);
      if (vt[r].e_ov) begin
        cmp("out_parity", r, bus.out_parity, vt[r].e_op);
        cmp("out_last",   r, bus.out_last,   vt[r].e_ol);
        cmp("word_err",   r, bus.word_err,   vt[r].e_we);
        if (vt[r].e_ol) cmp("frame_parity", r, bus.frame_parity, vt[r].e_fp);
      end
    end

    // Reset mid-frame: beat 1 (0x0001, not last) transfers so acc would be 1,
    // then reset while beat 2 sits at the output.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_data = 16'h0001; bus.in_last = 1'b0; bus.in_chk = 1'b0;
    bus.out_ready = 1'b1; odd_mode = 1'b0; chk_mode = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1 bus.in_data = 16'h0002;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    cmp("midrst_beat1_arrives", 100, bus.out_valid, 1'b1);
    @(posedge clk);
    #2;
    cmp("midrst_beat2_valid",  101, bus.out_valid,  1'b1);
    cmp("midrst_beat2_parity", 101, bus.out_parity, 1'b1);
    rst_n = 1'b0;
    #1;
    cmp("midrst_async_valid",  102, bus.out_valid,    1'b0);
    cmp("midrst_async_ready",  102, bus.in_ready,     1'b1);
    cmp("midrst_async_fp",     102, bus.frame_parity, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1; bus.in_data = 16'h8000; bus.in_last = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1;
    n = 1;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    cmp("post_rst_latency", 103, 8'(n),            8'd4);
    cmp("post_rst_valid",   103, bus.out_valid,    1'b1);
    cmp("post_rst_parity",  103, bus.out_parity,   1'b1);
    cmp("post_rst_last",    103, bus.out_last,     1'b1);
    cmp("post_rst_fp",      103, bus.frame_parity, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_pipe.md
Name: parity_pipe

Overview:
- Parametrised, pipelined parity generator/checker. It is the next generation of the team's 4-input XOR-tree parity cell.
- Input word is WIDTH bits. A binary XOR tree reduces it, with one register stage per tree level.
- Adds a valid/ready handshake with backpressure, even/odd mode, per-frame parity accumulation, and a check mode with a saturating error counter.
- Sits between a data source and a link/storage interface. Generates or verifies parity per word and per frame.

Parameters:
- WIDTH, 16, input word width; power of two, 2..64.
- STAGES, log2(WIDTH), number of pipeline register levels (derived, not overridable).
- ERRW, 8, error counter width.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, block accepts beat.
- in_data, in, WIDTH, word to reduce.
- in_chk, in, 1, expected parity bit (used in check mode).
- in_last, in, 1, final beat of frame.
- odd_mode, in, 1, 0 = even parity, 1 = odd parity; quasi-static.
- chk_mode, in, 1, 1 = check in_chk, 0 = generate only; quasi-static.
- clr, in, 1, synchronous clear of frame accumulator and error counter.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream accepts.
- out_parity, out, 1, word parity = XOR(in_data) ^ odd_mode.
- out_last, out, 1, in_last delayed with its word.
- frame_parity, out, 1, parity of all words of the frame ^ odd_mode; meaningful when out_valid & out_last.
- word_err, out, 1, out_parity != carried in_chk while chk_mode=1; 0 when chk_mode=0.
- err_cnt, out, ERRW, saturating count of accepted beats with word_err=1.

Behaviour:
- Reset (rst_n=0, async): all pipeline valid bits = 0; out_valid = 0, out_parity = 0, out_last = 0, frame_parity = 0, word_err = 0, err_cnt = 0, frame accumulator = 0. Deassertion is synchronised externally.
- Pipeline:
  - Stage k (1..STAGES) holds WIDTH>>k partial XORs, plus a valid bit, in_last and in_chk.
  - The final stage output is the single reduced bit.
  - Latency is STAGES cycles from input acceptance to out_valid with no stall (WIDTH=16 -> 4).
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - stall = out_valid & ~out_ready. in_ready = ~stall, purely combinational from the last stage.
  - While stall, every stage holds its value, including bubbles; no beat is lost or duplicated.
  - Without stall, bubbles propagate (stage valid = previous stage valid).
- odd_mode/chk_mode are applied at the output stage; changing them with beats in flight affects those beats. Changes are legal only when the pipeline is empty.
- Frame accumulator acc (1 bit):
  - On each output transfer: if out_last, acc <= 0; else acc <= acc ^ raw_parity.
  - frame_parity = acc ^ raw_parity ^ odd_mode, combinational on the output beat.
  - Single-beat frame: frame_parity = out_parity.
- Error counter:
  - Increments on an output transfer with word_err=1.
  - Holds at 2^ERRW-1 (saturation).
  - Not incremented on stalled cycles.
- clr:
  - Zeroes acc and err_cnt next edge; pipeline contents are untouched.
  - clr wins over a same-cycle increment or accumulate.
- Reset mid-frame discards all in-flight beats and the partial frame.
- Backpressure mid-frame does not alter acc.

Test Plan:
- WIDTH=16, even, chk_mode=0: single beat in_data=0x0001, in_last=1, out_ready=1 -> out_valid in cycle 4 after accept, out_parity=1, frame_parity=1, err_cnt=0.
- odd_mode=1, frame of 3 beats 0x0003, 0x0007, 0xFFFF (last), back-to-back:
  - out_parity = 1, 0, 1 on consecutive cycles.
  - frame_parity on beat 3 = 0^1^0^1 = 0.
  - Next frame starts with acc=0.
- Stall: stream 6 beats 0x0001..0x0006, out_ready=0 for cycles 5-8 -> in_ready=0 during stall; all 6 outputs delivered in order, each exactly once; parities 1,1,0,1,0,0.
- Check mode, even: send 0x00FF with in_chk=1, then 0x00FE with in_chk=1 -> word_err = 1 then 0; err_cnt = 1.
- Saturation/clr: ERRW=2, 5 error beats -> err_cnt = 3. Then clr with a simultaneous error beat -> err_cnt = 0.
- Reset mid-operation: assert rst_n=0 for one cycle after 2 of 3 frame beats are in flight -> out_valid=0 immediately (async); after release, a new single-beat frame 0x8000 gives frame_parity=1 (no residue).
